// File: rtl/prog_clk_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
`timescale 1ns/1ps
package clk_div_pkg;

    // Smallest divide ratio the output stage can produce.
    localparam int DIV_MIN = 2;

    // Number of source cycles pos_hi stays high within one output period of ratio n.
    function automatic logic [31:0] half_high(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the programmable clock divider.
`timescale 1ns/1ps
interface prog_clk_divider_if #(
    parameter int CNT_W = 10
);
    logic             en_i;
    logic [CNT_W-1:0] div_i;
    logic             div_load_i;
    logic             clk_o;
    logic             tick_o;
    logic [CNT_W-1:0] cur_div_o;
    logic             pend_o;
    logic             err_o;
    logic             active_o;

    // Requester side: drives run/ratio requests, observes the divided clock.
    modport master (
        output en_i, div_i, div_load_i,
        input  clk_o, tick_o, cur_div_o, pend_o, err_o, active_o
    );

    // Divider side.
    modport slave (
        input  en_i, div_i, div_load_i,
        output clk_o, tick_o, cur_div_o, pend_o, err_o, active_o
    );
endinterface

// File: rtl/prog_clk_divider_ratio_ctrl.sv
// Ratio bookkeeping: validates loads, holds a pending ratio and swaps it in
// only at output-period boundaries so the running period is never disturbed.
`timescale 1ns/1ps
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int DIV_RST = 7
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load_i,
    input  logic             boundary_i,
    output logic [CNT_W-1:0] cur_div_o,
    output logic             pend_o,
    output logic             err_o
);

    logic [CNT_W-1:0] pend_div_reg;
    logic [CNT_W-1:0] cur_div_reg;
    logic             pend_reg;
    logic             err_reg;
    logic             load_ok;
    logic             load_bad;

    assign load_ok  = div_load_i && (div_i >= CNT_W'(DIV_MIN));
    assign load_bad = div_load_i && (div_i <  CNT_W'(DIV_MIN));

    // A load arriving on a boundary edge wins over the apply-clear, so it waits for the next boundary.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pend_div_reg <= CNT_W'(DIV_RST);
            cur_div_reg  <= CNT_W'(DIV_RST);
            pend_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= load_bad;
            if (boundary_i && pend_reg) begin
                cur_div_reg <= pend_div_reg;
                pend_reg    <= 1'b0;
            end
            if (load_ok) begin
                pend_div_reg <= div_i;
                pend_reg     <= 1'b1;
            end
        end
    end

    assign cur_div_o = cur_div_reg;
    assign pend_o    = pend_reg;
    assign err_o     = err_reg;

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even
// ratios. clk_o is formed only from flops: pos_hi for even ratios, and
// pos_hi AND a negedge-delayed copy for odd ratios (half-cycle stretch).
`timescale 1ns/1ps
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int DIV_RST = 7
) (
    input  logic              clk_i,
    input  logic              rst_n,
    prog_clk_divider_if.slave bus
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cur_div;
    logic [31:0]      high_cnt;
    logic             run_reg;
    logic             pos_hi_reg;
    logic             neg_hi_reg;
    logic             tick_reg;
    logic             pend;
    logic             err;
    logic             wrap;
    logic             start;
    logic             boundary;

    assign cnt_inc  = cnt_reg + CNT_W'(1);
    assign high_cnt = half_high(32'(cur_div));
    assign wrap     = run_reg && (cnt_reg == (cur_div - CNT_W'(1)));
    assign start    = !run_reg && bus.en_i;
    assign boundary = start || wrap;

    clk_div_ratio_ctrl #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) u_ratio_ctrl (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .div_i      (bus.div_i),
        .div_load_i (bus.div_load_i),
        .boundary_i (boundary),
        .cur_div_o  (cur_div),
        .pend_o     (pend),
        .err_o      (err)
    );

    // Period counter, run control and the posedge half of the output stage.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            pos_hi_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else if (start) begin
            cnt_reg    <= '0;
            run_reg    <= 1'b1;
            pos_hi_reg <= 1'b1;
            tick_reg   <= 1'b1;
        end else if (wrap) begin
            // A stop request only takes effect here, after the period has completed.
            cnt_reg    <= '0;
            run_reg    <= bus.en_i;
            pos_hi_reg <= bus.en_i;
            tick_reg   <= bus.en_i;
        end else if (run_reg) begin
            cnt_reg    <= cnt_inc;
            pos_hi_reg <= (32'(cnt_inc) < high_cnt);
            tick_reg   <= 1'b0;
        end else begin
            pos_hi_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end
    end

    // Half-cycle delayed copy of pos_hi used to stretch odd-ratio high time.
    always_ff @(negedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            neg_hi_reg <= 1'b0;
        end else begin
            neg_hi_reg <= pos_hi_reg;
        end
    end

    // cur_div parity only changes at a boundary, where both stage flops are low before the edge.
    assign bus.clk_o     = cur_div[0] ? (pos_hi_reg & neg_hi_reg) : pos_hi_reg;
    assign bus.tick_o    = tick_reg;
    assign bus.cur_div_o = cur_div;
    assign bus.pend_o    = pend;
    assign bus.err_o     = err;
    assign bus.active_o  = run_reg;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: a ratio table measured in half-cycles,
// plus hand-written sequences for loads, errors, stop/start and reset.
`timescale 1ns/1ps
module tb_prog_clk_divider;

    localparam int CNT_W = 10;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    prog_clk_divider_if #(.CNT_W(CNT_W)) bus_if ();

    prog_clk_divider #(
        .CNT_W   (CNT_W),
        .DIV_RST (7)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int div;
        int hi_halves;
        int lo_halves;
        int tick_per;
    } vec_t;

    vec_t vecs [8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Measure one clk_o high and low phase in half-cycles, starting from the next rise.
    task automatic measure_clk(input string name, output int hi, output int lo);
        logic prev;
        int   guard;
        hi = -1;
        lo = -1;
        guard = 0;
        prev = bus_if.clk_o;
        forever begin
            @(clk_i); #1;
            if (!prev && bus_if.clk_o) break;
            prev = bus_if.clk_o;
            if (++guard > 6000) begin timeout({name, "_rise"}); return; end
        end
        hi = 1;
        forever begin
            @(clk_i); #1;
            if (!bus_if.clk_o) break;
            hi++;
            if (hi > 6000) begin timeout({name, "_fall"}); return; end
        end
        lo = 1;
        forever begin
            @(clk_i); #1;
            if (bus_if.clk_o) break;
            lo++;
            if (lo > 6000) begin timeout({name, "_low"}); return; end
        end
    endtask

    // Cycles between two consecutive ticks; ends sampled just after the second tick edge.
    task automatic measure_tick(input string name, output int period);
        int guard;
        period = -1;
        guard = 0;
        do begin
            @(posedge clk_i); #1;
            if (++guard > 3000) begin timeout({name, "_tick1"}); return; end
        end while (!bus_if.tick_o);
        period = 0;
        do begin
            @(posedge clk_i); #1;
            period++;
            if (period > 3000) begin timeout({name, "_tick2"}); period = -1; return; end
        end while (!bus_if.tick_o);
    endtask

    // Wait until the ratio in effect becomes d, noting whether value forbid ever appeared.
    task automatic wait_cur(input string name, input int d, input int forbid, output bit saw_forbid);
        int guard;
        guard = 0;
        saw_forbid = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (int'(bus_if.cur_div_o) == forbid) saw_forbid = 1'b1;
            if (int'(bus_if.cur_div_o) == d) break;
            if (++guard > 3000) begin timeout(name); return; end
        end
    endtask

    task automatic load(input int d);
        @(negedge clk_i);
        bus_if.div_i      = CNT_W'(d);
        bus_if.div_load_i = 1'b1;
        @(negedge clk_i);
        bus_if.div_load_i = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  hi, lo, per, cnt;
        bit  saw;

        vecs[0] = '{div: 2,    hi_halves: 2,    lo_halves: 2,    tick_per: 2};
        vecs[1] = '{div: 3,    hi_halves: 3,    lo_halves: 3,    tick_per: 3};
        vecs[2] = '{div: 5,    hi_halves: 5,    lo_halves: 5,    tick_per: 5};
        vecs[3] = '{div: 6,    hi_halves: 6,    lo_halves: 6,    tick_per: 6};
        vecs[4] = '{div: 7,    hi_halves: 7,    lo_halves: 7,    tick_per: 7};
        vecs[5] = '{div: 10,   hi_halves: 10,   lo_halves: 10,   tick_per: 10};
        vecs[6] = '{div: 4,    hi_halves: 4,    lo_halves: 4,    tick_per: 4};
        vecs[7] = '{div: 1023, hi_halves: 1023, lo_halves: 1023, tick_per: 1023};

        bus_if.en_i       = 1'b0;
        bus_if.div_i      = '0;
        bus_if.div_load_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_clk_o",   bus_if.clk_o,     0);
        check("rst_tick",    bus_if.tick_o,    0);
        check("rst_active",  bus_if.active_o,  0);
        check("rst_cur_div", bus_if.cur_div_o, 7);
        check("rst_pend",    bus_if.pend_o,    0);
        check("rst_err",     bus_if.err_o,     0);
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("idle_active", bus_if.active_o, 0);

        // 1: start with reset ratio 7
        @(negedge clk_i);
        bus_if.en_i = 1'b1;
        @(posedge clk_i); #1;
        check("t1_start_tick",   bus_if.tick_o,   1);
        check("t1_start_active", bus_if.active_o, 1);
        check("t1_clk_low_edge", bus_if.clk_o,    0);
        @(negedge clk_i); #1;
        check("t1_clk_rise_neg", bus_if.clk_o,    1);
        measure_clk("t1", hi, lo);
        check("t1_hi_halves", hi, 7);
        check("t1_lo_halves", lo, 7);
        measure_tick("t1", per);
        check("t1_tick_per", per, 7);
        check("t1_cur_div", bus_if.cur_div_o, 7);

        // 2: load 4 mid-period
        @(posedge clk_i); @(posedge clk_i);
        load(4);
        #1;
        check("t2_pend_set", bus_if.pend_o, 1);
        wait_cur("t2_apply", 4, -1, saw);
        check("t2_cur_div",   bus_if.cur_div_o, 4);
        check("t2_pend_clr",  bus_if.pend_o,    0);
        measure_clk("t2", hi, lo);
        check("t2_hi_halves", hi, 4);
        check("t2_lo_halves", lo, 4);

        // Ratio table (covers 2 and 3 exact-duty corner cases and the maximum ratio)
        for (int i = 0; i < 8; i++) begin
            load(vecs[i].div);
            #1;
            check($sformatf("v%0d_pend_set", vecs[i].div), bus_if.pend_o, 1);
            wait_cur($sformatf("v%0d_apply", vecs[i].div), vecs[i].div, -1, saw);
            check($sformatf("v%0d_cur_div", vecs[i].div), bus_if.cur_div_o, vecs[i].div);
            check($sformatf("v%0d_pend_clr", vecs[i].div), bus_if.pend_o, 0);
            measure_clk($sformatf("v%0d", vecs[i].div), hi, lo);
            check($sformatf("v%0d_hi_halves", vecs[i].div), hi, vecs[i].hi_halves);
            check($sformatf("v%0d_lo_halves", vecs[i].div), lo, vecs[i].lo_halves);
            measure_tick($sformatf("v%0d", vecs[i].div), per);
            check($sformatf("v%0d_tick_per", vecs[i].div), per, vecs[i].tick_per);
        end

        // 3: two loads inside one period (last wins), then rejected loads
        measure_tick("t3_align", per);
        @(negedge clk_i);
        bus_if.div_i = CNT_W'(5); bus_if.div_load_i = 1'b1;
        @(negedge clk_i);
        bus_if.div_i = CNT_W'(9);
        @(negedge clk_i);
        bus_if.div_load_i = 1'b0;
        wait_cur("t3_apply", 9, 5, saw);
        check("t3_cur_div_9", bus_if.cur_div_o, 9);
        check("t3_never_5",   saw, 0);
        load(1);
        #1;
        check("t3_err_pulse",   bus_if.err_o,     1);
        check("t3_err_pend",    bus_if.pend_o,    0);
        check("t3_err_cur_div", bus_if.cur_div_o, 9);
        @(negedge clk_i); #1;
        check("t3_err_one_cyc", bus_if.err_o,     0);
        load(6);
        load(0);
        #1;
        check("t3_err0_pulse",  bus_if.err_o,  1);
        check("t3_err0_pend",   bus_if.pend_o, 1);
        wait_cur("t3_apply6", 6, -1, saw);
        check("t3_cur_div_6", bus_if.cur_div_o, 6);

        // Cancelled stop: en dropped for one cycle mid-period keeps running
        measure_tick("t5c_align", per);
        @(negedge clk_i); bus_if.en_i = 1'b0;
        @(negedge clk_i); bus_if.en_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i); #1;
            if (!bus_if.active_o) cnt++;
        end
        check("t5_cancel_inactive_cycles", cnt, 0);

        // 5: stop at cnt = 2 with N = 6
        measure_tick("t5_align", per);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("t5_clk_hi_cnt2", bus_if.clk_o, 1);
        @(negedge clk_i); bus_if.en_i = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("t5_active_cnt%0d", k), bus_if.active_o, 1);
            check($sformatf("t5_clk_lo_cnt%0d", k), bus_if.clk_o,    0);
        end
        @(posedge clk_i); #1;
        check("t5_active_wrap", bus_if.active_o, 0);
        check("t5_tick_wrap",   bus_if.tick_o,   0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(clk_i); #1;
            if (bus_if.clk_o || bus_if.tick_o || bus_if.active_o) cnt++;
        end
        check("t5_idle_activity", cnt, 0);
        @(negedge clk_i); bus_if.en_i = 1'b1;
        @(posedge clk_i); #1;
        check("t5_restart_tick",   bus_if.tick_o,   1);
        check("t5_restart_clk",    bus_if.clk_o,    1);
        check("t5_restart_active", bus_if.active_o, 1);

        // 6: asynchronous reset while clk_o is high
        cnt = 0;
        while (!bus_if.clk_o && cnt < 100) begin
            @(clk_i); #1;
            cnt++;
        end
        #2;
        rst_n = 1'b0;
        bus_if.en_i = 1'b0;
        #1;
        check("t6_clk_async_low", bus_if.clk_o,     0);
        check("t6_tick",          bus_if.tick_o,    0);
        check("t6_active",        bus_if.active_o,  0);
        check("t6_cur_div",       bus_if.cur_div_o, 7);
        check("t6_pend",          bus_if.pend_o,    0);
        check("t6_err",           bus_if.err_o,     0);
        @(negedge clk_i);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(clk_i); #1;
            if (bus_if.clk_o || bus_if.tick_o || bus_if.active_o) cnt++;
        end
        check("t6_idle_activity", cnt, 0);
        @(negedge clk_i); bus_if.en_i = 1'b1;
        @(posedge clk_i); #1;
        check("t6_restart_tick", bus_if.tick_o, 1);
        measure_tick("t6", per);
        check("t6_tick_per", per, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable integer clock divider: divides clk_i by any N in [2, 2^CNT_W-1].
- Output has 50% duty for both odd and even N; odd N uses a negedge half-cycle stretch stage.
- Ratio changes and enable/disable take effect only at output-period boundaries, so clk_o never glitches.
- Sits in the clock-generation area and feeds slow peripheral clocks and strobes from the system clock.

Parameters:
- CNT_W, 10, counter and ratio width in bits.
- DIV_RST, 7, ratio loaded at reset; legal range 2..2^CNT_W-1.

Ports:
- clk_i  input  1  source clock.
- rst_n  input  1  asynchronous, active-low reset.
- en_i  input  1  run request; level-sensitive.
- div_i  input  CNT_W  requested divide ratio N.
- div_load_i  input  1  one-cycle strobe; captures div_i.
- clk_o  output  1  divided clock.
- tick_o  output  1  one clk_i-cycle pulse at the start of each output period.
- cur_div_o  output  CNT_W  ratio currently in effect.
- pend_o  output  1  a loaded ratio is waiting for the next boundary.
- err_o  output  1  one-cycle pulse when a load is rejected (div_i < 2).
- active_o  output  1  divider is running.

Behaviour:
- Reset (async, rst_n low) values:
  - cnt = 0, cur_div = DIV_RST, pend = 0, run = 0.
  - pos_hi = 0, neg_hi = 0.
  - Outputs: clk_o = 0, tick_o = 0, err_o = 0, active_o = 0, cur_div_o = DIV_RST.
- High count: H(N) = (N+1)>>1. Counter cnt runs 0..N-1 on posedge clk_i while run = 1.
- pos_hi (posedge register) is set to 1 iff the value cnt takes at that edge is < H(N) and run is 1 after that edge.
- neg_hi (negedge clk_i register) samples pos_hi.
- clk_o for even N: clk_o = pos_hi; high N/2 cycles, low N/2 cycles.
- clk_o for odd N: clk_o = pos_hi & neg_hi; rises half a cycle after cnt→0, falls on the posedge where cnt→H.
  - High time is H-0.5 = N/2 cycles.
- clk_o is registered-only logic (an AND of two flops). It has no combinational path from div_i or en_i.
- Boundary: the posedge where cnt wraps N-1→0, or the idle→run start edge.
- Ratio load:
  - div_load_i with div_i ≥ 2: pend_div <= div_i, pend = 1 on the next edge.
  - A new load while pending overwrites pend_div (last one wins).
  - div_i < 2: load ignored, err_o pulses 1 cycle, pend unchanged.
- Apply: at a boundary with pend = 1, cur_div <= pend_div and pend <= 0. The new N governs the period starting at that boundary.
  - A load in the same cycle as the boundary applies at the following boundary.
- Start: idle with en_i = 1 → next edge run = 1, cnt = 0, pos_hi = 1, tick_o = 1. Pending ratio is applied here too.
- Stop: en_i = 0 while running → current period completes.
  - At the wrap edge run <= 0, cnt holds 0, clk_o stays 0, no tick.
  - en_i re-asserted before the wrap cancels the stop.
- tick_o = 1 on the clk_i cycle following every edge where cnt becomes 0 with run = 1.
- active_o = run. cur_div_o = cur_div. pend_o = pend.
- Reset mid-period: clk_o forced low immediately, asynchronously; the divider restarts only when en_i = 1 after reset release.

Decomposition:
- Package clk_div_pkg:
  - Constant DIV_MIN = 2.
  - Function half_high(N) returns (N+1)>>1.
- Sub-module clk_div_ratio_ctrl, holding:
  - load validation, err_o generation;
  - pend_div/pend registers;
  - boundary-apply of cur_div.
- Top level keeps the counter, run control, posedge/negedge output stage and tick generation.

Test Plan:
1. Reset release, en_i = 1, DIV_RST = 7 → clk_o period 7 cycles, high 3.5 cycles (rises on negedge), tick_o every 7 cycles, cur_div_o = 7.
2. Load div_i = 4 mid-period → pend_o = 1 until the wrap; next period 4 cycles, high exactly 2; clk_o has no pulse shorter than 2 cycles.
3. Load 5 then 9 before the boundary → 9 applied, 5 never appears. Load div_i = 1 → err_o 1-cycle pulse, cur_div_o unchanged, pend_o unchanged.
4. N = 2 then N = 3 → 1-high/1-low, then 1.5-high/1.5-low; the duty-cycle checker measures both edges to ±0 half-cycles.
5. en_i dropped at cnt = 2 with N = 6 → clk_o completes 3 high + 3 low, then stays 0; active_o falls at the wrap. en_i re-raised → tick_o and clk_o rise on the next edge.
6. rst_n asserted while clk_o = 1 → clk_o = 0 asynchronously, all outputs at reset values, no activity until en_i.
